// File: rtl/led_pattern_gen.sv
// LED pattern generator.
// A prescaler divides the enabled clock down to one pattern step every DIV
// enabled cycles. Four patterns are selectable: alternate, rotate, ping-pong
// and binary count. A change of the mode input reloads the selected pattern's
// start value immediately. Outputs are registered.
// WIDTH must be even and at least 2; DIV must be at least 1.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    // A single-value prescaler (DIV=1) still needs a 1-bit counter.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [WIDTH-1:0] ALT_INIT = {WIDTH/2{2'b01}};
    localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_ALT   = 2'd0,
        MODE_ROT   = 2'd1,
        MODE_PING  = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    // Ping-pong travel direction.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [CNT_W-1:0] r_cnt;
    mode_t            r_mode_q;
    dir_t             r_dir;

    logic             w_tick;
    logic             w_mode_chg;
    logic [WIDTH-1:0] w_led_next;
    dir_t             w_dir_next;
    logic [WIDTH-1:0] w_led_init;

    assign w_tick     = en && (r_cnt == CNT_MAX);
    assign w_mode_chg = (mode != r_mode_q);

    // Start value of the pattern being switched to.
    always_comb begin
        w_led_init = ALT_INIT;
        case (mode_t'(mode))
            MODE_ALT:   w_led_init = ALT_INIT;
            MODE_ROT:   w_led_init = ONE_HOT0;
            MODE_PING:  w_led_init = ONE_HOT0;
            MODE_COUNT: w_led_init = '0;
            default:    w_led_init = ALT_INIT;
        endcase
    end

    // Next pattern value and ping-pong direction for a tick in the current mode.
    // The direction flips on the same step that lands on an endpoint, so each
    // endpoint is shown for exactly one step per bounce.
    always_comb begin
        w_led_next = led;
        w_dir_next = r_dir;
        case (r_mode_q)
            MODE_ALT: begin
                w_led_next = ~led;
            end
            MODE_ROT: begin
                w_led_next = {led[WIDTH-2:0], led[WIDTH-1]};
            end
            MODE_PING: begin
                if (r_dir == DIR_LEFT) begin
                    w_led_next = led << 1;
                    if (w_led_next[WIDTH-1]) begin
                        w_dir_next = DIR_RIGHT;
                    end
                end else begin
                    w_led_next = led >> 1;
                    if (w_led_next[0]) begin
                        w_dir_next = DIR_LEFT;
                    end
                end
            end
            MODE_COUNT: begin
                w_led_next = led + WIDTH'(1);
            end
            default: begin
                w_led_next = led;
            end
        endcase
    end

    // State update, priority: reset, mode change, tick, hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            led      <= ALT_INIT;
            r_cnt    <= '0;
            r_mode_q <= MODE_ALT;
            r_dir    <= DIR_LEFT;
            step     <= 1'b0;
        end else if (w_mode_chg) begin
            led      <= w_led_init;
            r_cnt    <= '0;
            r_mode_q <= mode_t'(mode);
            r_dir    <= DIR_LEFT;
            step     <= 1'b0;
        end else if (en) begin
            step <= w_tick;
            if (w_tick) begin
                r_cnt <= '0;
                led   <= w_led_next;
                r_dir <= w_dir_next;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            step <= 1'b0;
        end
    end

endmodule
